drum_mem_ctrl: RTL and testbench



---
 rtl/drum_mem_ctrl_if.sv | 47 ++++
 rtl/drum_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_drum_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_mem_ctrl_if.sv
// rtl/drum_mem_ctrl_if.sv - Memory handshake bundle between the pulse sequencer and the drum controller
//
// Purpose: groups the request/response signals of the drum memory handshake.
// Ports (master = initiator / pulse sequencer, slave = drum_mem_ctrl):
//   read_enable  master->slave  read request, held until mem_finish
//   write_enable master->slave  write request, held until mem_finish
//   addr         master->slave  word address, sampled on acceptance
//   wdata        master->slave  write data, sampled on acceptance
//   rdata        slave->master  registered read data, held until the next read completes
//   mem_finish   slave->master  one-cycle completion pulse
//   busy         slave->master  a request is in flight
//   drum_pos     slave->master  sector currently under the head
interface drum_mem_ctrl_if #(
  parameter int WORD_W = 31,
  parameter int ADDR_W = 10
);
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              mem_finish;
  logic              busy;
  logic [ADDR_W-1:0] drum_pos;

  modport master (
    output read_enable,
    output write_enable,
    output addr,
    output wdata,
    input  rdata,
    input  mem_finish,
    input  busy,
    input  drum_pos
  );

  modport slave (
    input  read_enable,
    input  write_enable,
    input  addr,
    input  wdata,
    output rdata,
    output mem_finish,
    output busy,
    output drum_pos
  );
endinterface

// File: rtl/drum_mem_ctrl.sv
// rtl/drum_mem_ctrl.sv - Rotating magnetic drum memory emulator answering the sequencer handshake
//
// Purpose: accepts read/write requests and completes each one only while the
// addressed word slot passes under the head. One slot lasts SECTOR_CYCLES
// clocks; the drum turns continuously regardless of activity.
// Ports:
//   clk    system clock, rising edge
//   resetn synchronous active-low reset
//   bus    drum_mem_ctrl_if.slave: read_enable, write_enable, addr, wdata in;
//          rdata, mem_finish, busy, drum_pos out (all outputs registered)
module drum_mem_ctrl #(
  parameter int WORD_W        = 31,
  parameter int ADDR_W        = 10,
  parameter int SECTOR_CYCLES = 4
) (
  input  logic           clk,
  input  logic           resetn,
  drum_mem_ctrl_if.slave bus
);

  localparam int                SLOT_W    = (SECTOR_CYCLES > 2) ? $clog2(SECTOR_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SECTOR_CYCLES - 1);
  localparam int                DEPTH     = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_e;

  state_e            state_q,      state_d;
  logic [SLOT_W-1:0] slot_cnt_q,   slot_cnt_d;
  logic [ADDR_W-1:0] drum_pos_q,   drum_pos_d;
  logic [ADDR_W-1:0] lat_addr_q,   lat_addr_d;
  logic [WORD_W-1:0] lat_wdata_q,  lat_wdata_d;
  logic              lat_we_q,     lat_we_d;
  logic [WORD_W-1:0] rdata_q,      rdata_d;
  logic              mem_finish_q, mem_finish_d;
  logic              busy_q,       busy_d;

  logic              slot_last;
  logic              next_is_target;
  logic              write_now;

  logic [WORD_W-1:0] mem [DEPTH];

  always_comb begin
    // Free-running rotation: a slot ends on its last cycle and the next
    // sector (mod 2**ADDR_W) comes under the head.
    slot_last  = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
    drum_pos_d = slot_last ? drum_pos_q + 1'b1 : drum_pos_q;

    // Entering XFER exactly at the start of the target slot means deciding
    // on the last cycle of the preceding slot. A request latched on or after
    // that point has already missed the slot and waits a full revolution.
    next_is_target = slot_last && (drum_pos_d == lat_addr_q);

    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_we_d    = lat_we_q;
    rdata_d     = rdata_q;
    write_now   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.write_enable || bus.read_enable) begin
          // A simultaneous read and write request is serviced as a write.
          lat_we_d    = bus.write_enable;
          lat_addr_d  = bus.addr;
          lat_wdata_d = bus.wdata;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (next_is_target) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // The access happens on the edge closing the slot, so the whole slot
        // has passed under the head before data moves.
        if (slot_last) begin
          state_d = DONE;
          if (lat_we_q) begin
            write_now = 1'b1;
          end else begin
            rdata_d = mem[lat_addr_q];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_finish_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      slot_cnt_q   <= '0;
      drum_pos_q   <= '0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_we_q     <= 1'b0;
      rdata_q      <= '0;
      mem_finish_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      drum_pos_q   <= drum_pos_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_we_q     <= lat_we_d;
      rdata_q      <= rdata_d;
      mem_finish_q <= mem_finish_d;
      busy_q       <= busy_d;
    end
  end

  // Storage is never cleared. A reset arriving before the closing edge of
  // the write slot drops the write; earlier completed writes are kept.
  always_ff @(posedge clk) begin
    if (resetn && write_now) begin
      mem[lat_addr_q] <= lat_wdata_q;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.mem_finish = mem_finish_q;
  assign bus.busy       = busy_q;
  assign bus.drum_pos   = drum_pos_q;

endmodule

// File: tb/tb_drum_mem_ctrl.sv
// tb/tb_drum_mem_ctrl.sv - Self-checking bench for drum_mem_ctrl
module tb_drum_mem_ctrl;

  localparam int WORD_W = 31;
  localparam int ADDR_W = 3;
  localparam int SC     = 4;
  localparam int NSLOT  = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  drum_mem_ctrl_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  drum_mem_ctrl #(
    .WORD_W       (WORD_W),
    .ADDR_W       (ADDR_W),
    .SECTOR_CYCLES(SC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WORD_W-1:0] ref_mem [NSLOT];
  logic [WORD_W-1:0] model_rdata = '0;

  typedef struct {
    bit                we;
    bit                re;
    int                a;
    logic [WORD_W-1:0] wd;
    logic [WORD_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int pos_at(input int t);
    return (t / SC) % NSLOT;
  endfunction

  // Completion cycle of a request accepted at cycle acc: the transfer uses
  // the first whole target slot starting no earlier than acc+2 (acc+1 is the
  // first waiting cycle), then finishes one cycle after that slot.
  function automatic int finish_at(input int acc, input int a);
    int s;
    s = acc + 2;
    while (!((s % SC == 0) && (pos_at(s) == a))) s++;
    return s + SC;
  endfunction

  task automatic do_reset();
    resetn           = 1'b0;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    @(posedge clk);
    #1;
    model_rdata = '0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_finish", bus.mem_finish, 0);
    chk("rst_drum_pos", bus.drum_pos, 0);
    chk("rst_rdata", bus.rdata, 0);
    resetn = 1'b1;
    cyc    = 0;
  endtask

  task automatic op(input bit we, input bit re, input int a,
                    input logic [WORD_W-1:0] wd, output int fin_seen);
    int acc;
    int fin;
    bit done;
    acc      = cyc;
    fin      = finish_at(acc, a);
    fin_seen = -1;
    done     = 1'b0;
    chk("accept_idle", bus.busy, 0);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.addr         = 3'(a);
    bus.wdata        = wd;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (cyc == acc + 1) begin
        // Request already latched: everything on the bus must now be ignored.
        bus.addr         = 3'($urandom);
        bus.wdata        = 31'($urandom);
        bus.read_enable  = 1'($urandom);
        bus.write_enable = 1'($urandom);
      end
      if (cyc == fin) begin
        if (we) ref_mem[a] = wd;
        else    model_rdata = ref_mem[a];
      end
      chk("mem_finish", bus.mem_finish, (cyc == fin));
      chk("busy", bus.busy, 1);
      chk("drum_pos", bus.drum_pos, pos_at(cyc));
      chk("rdata", bus.rdata, model_rdata);
      if (cyc == 31) chk("pos_before_wrap", bus.drum_pos, 7);
      if (cyc == 32) chk("pos_wrap", bus.drum_pos, 0);
      if (bus.mem_finish === 1'b1) begin
        done     = 1'b1;
        fin_seen = cyc;
      end
    end
    chk("op_finish_cycle", fin_seen, fin);
  endtask

  task automatic idle_after(input int gap);
    tick();
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_finish", bus.mem_finish, 0);
    chk("idle_rdata", bus.rdata, model_rdata);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("idle_busy", bus.busy, 0);
      chk("idle_finish", bus.mem_finish, 0);
      chk("idle_drum_pos", bus.drum_pos, pos_at(cyc));
      chk("idle_rdata", bus.rdata, model_rdata);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int f;
    int acc;
    int s;
    bit we;
    bit re;

    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.addr         = '0;
    bus.wdata        = '0;

    vecs[0]  = '{1'b1, 1'b0, 0, 31'h11,       31'h1234567};
    vecs[1]  = '{1'b1, 1'b0, 1, 31'h22,       31'h1234567};
    vecs[2]  = '{1'b1, 1'b0, 3, 31'h33,       31'h1234567};
    vecs[3]  = '{1'b1, 1'b0, 4, 31'h7,        31'h1234567};
    vecs[4]  = '{1'b1, 1'b0, 5, 31'h55aa,     31'h1234567};
    vecs[5]  = '{1'b1, 1'b0, 6, 31'h66,       31'h1234567};
    vecs[6]  = '{1'b1, 1'b0, 7, 31'h7fffffff, 31'h1234567};
    vecs[7]  = '{1'b0, 1'b1, 5, 31'h0,        31'h55aa};
    vecs[8]  = '{1'b0, 1'b1, 0, 31'h0,        31'h11};
    vecs[9]  = '{1'b0, 1'b1, 7, 31'h0,        31'h7fffffff};
    vecs[10] = '{1'b0, 1'b1, 2, 31'h0,        31'h1234567};
    vecs[11] = '{1'b1, 1'b1, 6, 31'h606,      31'h1234567};
    vecs[12] = '{1'b0, 1'b1, 6, 31'h0,        31'h606};

    // Reset state, then write addr 2 from cycle 1 and read it back at 13.
    do_reset();
    tick();
    op(1'b1, 1'b0, 2, 31'h1234567, f);
    chk("t1_finish_at_12", f, 12);
    idle_after(0);
    op(1'b0, 1'b1, 2, 31'h0, f);
    chk("t2_finish_at_44", f, 44);
    chk("t2_rdata", bus.rdata, 31'h1234567);
    idle_after(3);
    chk("t2_rdata_held", bus.rdata, 31'h1234567);

    // Table-driven vectors: fill every address and read some back.
    for (int i = 0; i < 13; i++) begin
      op(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, f);
      chk("vec_rdata", bus.rdata, vecs[i].exp_rdata);
      idle_after(i % 3);
    end

    // Read accepted at the very first cycle of its slot waits a revolution.
    do_reset();
    while (cyc < 20) begin
      tick();
      chk("t3_drum_pos", bus.drum_pos, pos_at(cyc));
    end
    op(1'b0, 1'b1, 5, 31'h0, f);
    chk("t3_finish_at_56", f, 56);
    chk("t3_rdata", bus.rdata, 31'h55aa);
    idle_after(1);

    // Back-to-back write then read of the same address.
    op(1'b1, 1'b0, 3, 31'habcde, f);
    idle_after(0);
    op(1'b0, 1'b1, 3, 31'h0, f);
    chk("t4_rdata", bus.rdata, 31'habcde);
    idle_after(4);

    // Both enables high is a write and leaves rdata alone.
    op(1'b1, 1'b1, 1, 31'h55, f);
    chk("t5_rdata_unchanged", bus.rdata, 31'habcde);
    idle_after(1);
    op(1'b0, 1'b1, 1, 31'h0, f);
    chk("t5_rdata", bus.rdata, 31'h55);
    idle_after(1);

    // Reset during the last XFER cycle of a write to addr 4.
    acc = cyc;
    s   = finish_at(acc, 4) - SC;
    bus.write_enable = 1'b1;
    bus.addr         = 3'd4;
    bus.wdata        = 31'h1;
    while (cyc < s + SC - 1) begin
      tick();
      chk("t6_busy", bus.busy, 1);
      chk("t6_finish", bus.mem_finish, 0);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_post_finish", bus.mem_finish, 0);
      chk("t6_post_pos0", bus.drum_pos, 0);
    end
    tick();
    chk("t6_post_pos1", bus.drum_pos, 1);
    op(1'b0, 1'b1, 4, 31'h0, f);
    chk("t6_rdata", bus.rdata, 31'h7);
    idle_after(2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      op(we, re, $urandom_range(0, NSLOT - 1), 31'($urandom), f);
      idle_after($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
